// File: rtl/svm_decision_if.sv
// Output record stream of svm_decision: one {index, score, label} record per instance.
// Optional SVM_DECISION_MARGIN_EN adds the out_uncertain flag to the record.
interface svm_decision_if #(
    parameter int unsigned ACCUM_SIZE = 64,
    parameter int unsigned NUM_INST   = 2,
    parameter int unsigned IDX_W      = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
);
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             out_idx;
    logic signed [ACCUM_SIZE-1:0] out_score;
    logic                         out_label;
    logic                         out_last;
`ifdef SVM_DECISION_MARGIN_EN
    logic                         out_uncertain;
`endif

    modport master (
        output out_valid, out_idx, out_score, out_label, out_last,
`ifdef SVM_DECISION_MARGIN_EN
        output out_uncertain,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_score, out_label, out_last,
`ifdef SVM_DECISION_MARGIN_EN
        input  out_uncertain,
`endif
        output out_ready
    );
endinterface

// File: rtl/svm_decision.sv
// SVM decision stage: bias add with saturation, sign -> label, one record per instance.
// Optional SVM_DECISION_MARGIN_EN adds margin_i / out_uncertain / uncertain_o.
module svm_decision #(
    parameter int unsigned ACCUM_SIZE = 64,
    parameter int unsigned NUM_INST   = 2,
    parameter int unsigned IDX_W      = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        load_i,
    input  logic signed [NUM_INST-1:0][ACCUM_SIZE-1:0]  results_i,
    input  logic signed [ACCUM_SIZE-1:0]                bias_i,
`ifdef SVM_DECISION_MARGIN_EN
    input  logic [ACCUM_SIZE-1:0]                       margin_i,
    output logic [NUM_INST-1:0]                         uncertain_o,
`endif
    svm_decision_if.master                              out_if,
    output logic                                        busy_o,
    output logic [NUM_INST-1:0]                         labels_o,
    output logic                                        labels_valid_o,
    output logic                                        overrun_o
);

    localparam int unsigned W = ACCUM_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INST - 1);
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

    state_t                       state_q, state_d;
    logic [NUM_INST-1:0][W-1:0]   shadow_q, shadow_d;
    logic signed [W-1:0]          bias_q, bias_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         valid_q, valid_d;
    logic [IDX_W-1:0]             out_idx_q, out_idx_d;
    logic signed [W-1:0]          score_q, score_d;
    logic                         label_q, label_d;
    logic                         last_q, last_d;
    logic                         busy_q, busy_d;
    logic [NUM_INST-1:0]          labels_q, labels_d;
    logic                         labels_valid_q, labels_valid_d;
    logic                         overrun_q, overrun_d;
`ifdef SVM_DECISION_MARGIN_EN
    logic [W-1:0]                 margin_q, margin_d;
    logic                         unc_q, unc_d;
    logic [NUM_INST-1:0]          uncertain_q, uncertain_d;
    logic [W-1:0]                 mag_c;
`endif

    logic signed [W-1:0]          sel_c;
    logic [W:0]                   sum_c;
    logic signed [W-1:0]          sat_c;

    // Sign-extended add at W+1 bits; disagreement of the top two bits means overflow.
    always_comb begin
        sel_c = $signed(shadow_q[idx_q]);
        sum_c = {sel_c[W-1], sel_c} + {bias_q[W-1], bias_q};
        if (sum_c[W] != sum_c[W-1]) begin
            sat_c = sum_c[W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_c = $signed(sum_c[W-1:0]);
        end
`ifdef SVM_DECISION_MARGIN_EN
        if (!sat_c[W-1])          mag_c = sat_c;
        else if (sat_c == SAT_MIN) mag_c = SAT_MAX;
        else                       mag_c = W'(-sat_c);
`endif
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        bias_d         = bias_q;
        idx_d          = idx_q;
        valid_d        = valid_q;
        out_idx_d      = out_idx_q;
        score_d        = score_q;
        label_d        = label_q;
        last_d         = last_q;
        labels_d       = labels_q;
        labels_valid_d = labels_valid_q;
        overrun_d      = overrun_q;
`ifdef SVM_DECISION_MARGIN_EN
        margin_d       = margin_q;
        unc_d          = unc_q;
        uncertain_d    = uncertain_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    shadow_d       = results_i;
                    bias_d         = bias_i;
`ifdef SVM_DECISION_MARGIN_EN
                    margin_d       = margin_i;
`endif
                    idx_d          = '0;
                    labels_valid_d = 1'b0;
                    overrun_d      = 1'b0;
                    state_d        = CALC;
                end
            end
            CALC: begin
                score_d   = sat_c;
                label_d   = ~sat_c[W-1];
                out_idx_d = idx_q;
                last_d    = (idx_q == LAST_IDX);
`ifdef SVM_DECISION_MARGIN_EN
                unc_d     = (mag_c < margin_q);
`endif
                valid_d   = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                if (valid_q && out_if.out_ready) begin
                    labels_d[idx_q] = label_q;
`ifdef SVM_DECISION_MARGIN_EN
                    uncertain_d[idx_q] = unc_q;
`endif
                    valid_d = 1'b0;
                    if (last_q) begin
                        labels_valid_d = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load outside IDLE is dropped and flagged until the next accepted load.
        if (load_i && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            bias_q         <= '0;
            idx_q          <= '0;
            valid_q        <= 1'b0;
            out_idx_q      <= '0;
            score_q        <= '0;
            label_q        <= 1'b0;
            last_q         <= 1'b0;
            busy_q         <= 1'b0;
            labels_q       <= '0;
            labels_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef SVM_DECISION_MARGIN_EN
            margin_q       <= '0;
            unc_q          <= 1'b0;
            uncertain_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            bias_q         <= bias_d;
            idx_q          <= idx_d;
            valid_q        <= valid_d;
            out_idx_q      <= out_idx_d;
            score_q        <= score_d;
            label_q        <= label_d;
            last_q         <= last_d;
            busy_q         <= busy_d;
            labels_q       <= labels_d;
            labels_valid_q <= labels_valid_d;
            overrun_q      <= overrun_d;
`ifdef SVM_DECISION_MARGIN_EN
            margin_q       <= margin_d;
            unc_q          <= unc_d;
            uncertain_q    <= uncertain_d;
`endif
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_score = score_q;
    assign out_if.out_label = label_q;
    assign out_if.out_last  = last_q;
`ifdef SVM_DECISION_MARGIN_EN
    assign out_if.out_uncertain = unc_q;
    assign uncertain_o          = uncertain_q;
`endif
    assign busy_o         = busy_q;
    assign labels_o       = labels_q;
    assign labels_valid_o = labels_valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_svm_decision.sv
// Scoreboard bench for svm_decision (NUM_INST=2, ACCUM_SIZE=64): expected records are queued
// by the stimulus and popped by a monitor on each handshake.
module tb_svm_decision;

    localparam int unsigned W  = 64;
    localparam int unsigned N  = 2;
    localparam int unsigned IW = 1;

    localparam logic signed [W-1:0] SMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [W-1:0] SMIN = 64'sh8000_0000_0000_0000;

    typedef struct {
        logic [IW-1:0]       idx;
        logic signed [W-1:0] score;
        logic                label;
        logic                last;
    } rec_t;

    logic                        clk;
    logic                        rst_n;
    logic                        load;
    logic signed [N-1:0][W-1:0]  results;
    logic signed [W-1:0]         bias;
    logic                        busy;
    logic [N-1:0]                labels;
    logic                        labels_valid;
    logic                        overrun;
`ifdef SVM_DECISION_MARGIN_EN
    logic [W-1:0]                margin;
    logic [N-1:0]                uncertain;
`endif

    int   errors = 0;
    int   checks = 0;
    rec_t exp_q[$];

    svm_decision_if #(.ACCUM_SIZE(W), .NUM_INST(N)) bus ();

    svm_decision #(.ACCUM_SIZE(W), .NUM_INST(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load),
        .results_i      (results),
        .bias_i         (bias),
`ifdef SVM_DECISION_MARGIN_EN
        .margin_i       (margin),
        .uncertain_o    (uncertain),
`endif
        .out_if         (bus.master),
        .busy_o         (busy),
        .labels_o       (labels),
        .labels_valid_o (labels_valid),
        .overrun_o      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a record is consumed at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: idx=%0d score=%0d", bus.out_idx, bus.out_score);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("rec_idx",   W'(bus.out_idx),   W'(e.idx));
                chk("rec_score", bus.out_score,     e.score);
                chk("rec_label", W'(bus.out_label), W'(e.label));
                chk("rec_last",  W'(bus.out_last),  W'(e.last));
            end
        end
    end

    function automatic void push(logic [IW-1:0] i, logic signed [W-1:0] s, logic l, logic la);
        rec_t r;
        r.idx = i; r.score = s; r.label = l; r.last = la;
        exp_q.push_back(r);
    endfunction

    // One-cycle load pulse; returns one cycle after the load edge (+1 time unit).
    task automatic do_load(logic signed [W-1:0] r1, logic signed [W-1:0] r0, logic signed [W-1:0] b);
        @(posedge clk); #1;
        results = {r1, r0};
        bias    = b;
        load    = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
        results = '1;
        bias    = '1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || exp_q.size() != 0) chk("wait_done_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        results = '0;
        bias = '0;
        bus.out_ready = 1'b0;
`ifdef SVM_DECISION_MARGIN_EN
        margin = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_valid",        W'(bus.out_valid),  0);
        chk("rst_score",        bus.out_score,      0);
        chk("rst_busy",         W'(busy),           0);
        chk("rst_labels",       W'(labels),         0);
        chk("rst_labels_valid", W'(labels_valid),   0);
        chk("rst_overrun",      W'(overrun),        0);

        // Basic batch with latency check.
        bus.out_ready = 1'b1;
        push(0, 7, 1'b1, 1'b0);
        push(1, -10, 1'b0, 1'b1);
        do_load(-7, 10, -3);
        chk("lat_t1_valid", W'(bus.out_valid), 0);
        chk("lat_t1_busy",  W'(busy),          1);
        @(posedge clk); #1;
        chk("lat_t2_valid", W'(bus.out_valid), 1);
        chk("lat_t2_score", bus.out_score,     7);
        wait_done();
        chk("basic_labels",       W'(labels),       2'b01);
        chk("basic_labels_valid", W'(labels_valid), 1);
        chk("basic_overrun",      W'(overrun),      0);

        // Back-pressure: first record held for 5 cycles.
        bus.out_ready = 1'b0;
        push(0, 4, 1'b1, 1'b0);
        push(1, 25, 1'b1, 1'b1);
        do_load(20, -1, 5);
        chk("bp_labels_valid_cleared", W'(labels_valid), 0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", W'(bus.out_valid), 1);
            chk("bp_hold_idx",   W'(bus.out_idx),   0);
            chk("bp_hold_score", bus.out_score,     4);
            chk("bp_hold_label", W'(bus.out_label), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_gap_valid", W'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk("bp_next_valid", W'(bus.out_valid), 1);
        chk("bp_next_idx",   W'(bus.out_idx),   1);
        chk("bp_next_last",  W'(bus.out_last),  1);
        wait_done();
        chk("bp_labels", W'(labels), 2'b11);

        // Positive saturation.
        push(0, SMAX, 1'b1, 1'b0);
        push(1, 10, 1'b1, 1'b1);
        do_load(0, 64'sh7FFF_FFFF_FFFF_FFFB, 10);
        wait_done();
        chk("satp_labels", W'(labels), 2'b11);

        // Negative saturation.
        push(0, -10, 1'b0, 1'b0);
        push(1, SMIN, 1'b0, 1'b1);
        do_load(64'sh8000_0000_0000_0001, 0, -10);
        wait_done();
        chk("satn_labels", W'(labels), 2'b00);

        // Zero score gives label 1.
        push(0, 0, 1'b1, 1'b0);
        push(1, -103, 1'b0, 1'b1);
        do_load(-100, 3, -3);
        wait_done();
        chk("zero_labels", W'(labels), 2'b01);

        // Overrun: load during SEND is ignored and flagged.
        bus.out_ready = 1'b0;
        push(0, 2, 1'b1, 1'b0);
        push(1, 1, 1'b1, 1'b1);
        do_load(1, 2, 0);
        wait_valid();
        results = {64'sd100, 64'sd100};
        bias = 50;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("ovr_flag",  W'(overrun),       1);
        chk("ovr_valid", W'(bus.out_valid), 1);
        chk("ovr_score", bus.out_score,     2);
        chk("ovr_idx",   W'(bus.out_idx),   0);
        bus.out_ready = 1'b1;
        wait_done();
        chk("ovr_labels", W'(labels),  2'b11);
        chk("ovr_sticky", W'(overrun), 1);

        // Reset mid-batch.
        bus.out_ready = 1'b0;
        do_load(5, 5, 0);
        chk("ovr_cleared_by_load", W'(overrun), 0);
        wait_valid();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",        W'(bus.out_valid), 0);
        chk("mid_rst_score",        bus.out_score,     0);
        chk("mid_rst_busy",         W'(busy),          0);
        chk("mid_rst_labels",       W'(labels),        0);
        chk("mid_rst_labels_valid", W'(labels_valid),  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Normal batch after reset.
        bus.out_ready = 1'b1;
        push(0, 1, 1'b1, 1'b0);
        push(1, -1, 1'b0, 1'b1);
        do_load(-1, 1, 0);
        wait_done();
        chk("post_rst_labels",       W'(labels),       2'b01);
        chk("post_rst_labels_valid", W'(labels_valid), 1);
        chk("post_rst_overrun",      W'(overrun),      0);
        chk("queue_drained",         W'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svm_decision.md
Name: svm_decision

Overview:
Downstream stage of the result counter. Captures the per-instance kernel-sum array when the counter finishes, adds the model bias with saturation, and takes the sign to produce a class label per instance. Streams one {index, score, label} record per instance over a valid/ready interface. Also keeps a packed label vector for a register-mapped readout.

Parameters:
ACCUM_SIZE, 64, width of each signed accumulated result, bias and score.
NUM_INST, 2, number of instances per batch; legal range is 1 or more.
IDX_W, (NUM_INST>1 ? $clog2(NUM_INST) : 1), width of the instance index.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
load  in  1  single-cycle pulse: results array is final.
results  in  [NUM_INST-1:0][ACCUM_SIZE-1:0] signed  per-instance kernel sums.
bias  in  ACCUM_SIZE signed  model bias b; sampled on an accepted load.
out_valid  out  1  output record valid.
out_ready  in  1  consumer accepts the record.
out_idx  out  IDX_W  instance index of the record.
out_score  out  ACCUM_SIZE signed  saturated results[i]+bias.
out_label  out  1  1 when out_score >= 0, else 0.
out_last  out  1  record is for instance NUM_INST-1.
busy  out  1  high in every state except IDLE.
labels  out  NUM_INST  packed labels of the last completed batch; bit i is instance i.
labels_valid  out  1  labels holds a complete batch.
overrun  out  1  sticky: a load arrived while busy.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; internal index 0; shadow registers 0.
- States: IDLE, CALC, SEND.
- IDLE:
  - load=1: copy results and bias into shadow registers; idx<=0; clear labels_valid; go to CALC.
  - Otherwise stay in IDLE.
- CALC (one cycle): register out_score = sat(shadow[idx]+bias_s), out_label, out_idx=idx, out_last=(idx==NUM_INST-1); assert out_valid; go to SEND.
  - Latency: load in cycle t gives out_valid in cycle t+2.
- SEND:
  - out_valid=1 and out_ready=0: out_idx, out_score, out_label and out_last are held stable; out_valid stays high.
  - Handshake (out_valid & out_ready): labels[idx] <= out_label.
    - If out_last: drop out_valid, set labels_valid, go to IDLE.
    - Otherwise: idx<=idx+1, drop out_valid, go to CALC.
  - Throughput is one record per 2 cycles. This is accepted; no back-to-back records.
- Arithmetic:
  - Sum is computed at ACCUM_SIZE+1 bits.
  - On positive overflow, clamp to 2^(ACCUM_SIZE-1)-1. On negative overflow, clamp to -2^(ACCUM_SIZE-1).
  - Sign is taken after saturation; a score of exactly 0 gives label 1.
- load while busy: ignored (the shadow registers are not touched); overrun <= 1.
  - overrun clears only on reset or on the next load accepted in IDLE.
- load in the same cycle as the final handshake: the FSM is still busy, so this counts as overrun and the load is ignored.
- NUM_INST=1: out_last is 1 on every record; idx never increments.
- Reset mid-batch: aborts immediately. labels_valid=0 and labels=0 after reset; there is no partial output.
- The results input may change freely after the load cycle; only the shadow copy is used.

Optional Feature:
SVM_DECISION_MARGIN_EN. When defined, adds input `margin` (ACCUM_SIZE, unsigned, sampled with bias on an accepted load) and output `out_uncertain` (1).
- out_uncertain=1 when |out_score| < margin_s. For |x| use the saturated magnitude: |-2^(ACCUM_SIZE-1)| is treated as 2^(ACCUM_SIZE-1)-1.
- Also adds a packed output `uncertain` (NUM_INST), updated on each handshake alongside labels.
- When undefined, these ports and registers do not exist, and behaviour is exactly as above.

Test Plan:
- Basic batch (NUM_INST=2, ACCUM_SIZE=64): results={-7,10} (inst1,inst0), bias=-3, out_ready=1 -> out_valid at load+2. Records are: idx0 score 7 label 1; idx1 score -10 label 0 with out_last=1. Then labels=2'b01 and labels_valid=1.
- Back-pressure: out_ready=0 for 5 cycles after the first out_valid -> idx/score/label stay constant and out_valid stays high; after release the remaining record follows 2 cycles later.
- Saturation: results[0]=2^63-5, bias=10 -> score 2^63-1, label 1. results[1]=-2^63+1, bias=-10 -> score -2^63, label 0.
- Zero boundary: results[0]=3, bias=-3 -> score 0, label 1.
- Overrun and reset: a second load pulse during SEND -> overrun=1 and the output records are unchanged. Assert rst_n=0 mid-batch -> all outputs 0 asynchronously. After reset, a new load proceeds normally and overrun=0.
- With SVM_DECISION_MARGIN_EN: margin=5; scores 4, -5, -6 -> out_uncertain 1, 0, 0.
